// File: rtl/data_memory_ram.sv
// data_memory_ram: 1024x32 synchronous RAM, R/W port A, optional read-only port B, zero-fill sweep on reset
module data_memory_ram #(
   parameter int DATA_WIDTH     = 32,
   parameter int ADDR_WIDTH     = 10,
   parameter int ENABLE_PORT_B  = 1,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] address_a,
   input  logic [DATA_WIDTH-1:0] data_a,
   input  logic                  wren_a,
   output logic [DATA_WIDTH-1:0] q_a,
   input  logic [ADDR_WIDTH-1:0] address_b,
   output logic [DATA_WIDTH-1:0] q_b,
   output logic                  busy
);
   localparam int DEPTH = 2**ADDR_WIDTH;
   typedef enum logic {IDLE, CLEAR} state_t;
   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] counter_q, counter_d, waddr;
   logic [DATA_WIDTH-1:0] wdata, q_a_q;
   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic                  clearing, we;
   // next sweep state/counter and the single shared write port mux
   always_comb begin
      clearing  = state_q == CLEAR;
      state_d   = (clearing && &counter_q) ? IDLE : state_q;
      counter_d = clearing ? counter_q + 1'b1 : counter_q;
      we        = !rst && (clearing || wren_a);
      waddr     = clearing ? counter_q : address_a;
      wdata     = clearing ? '0 : data_a;
   end
   // sweep state register; reset restarts the sweep from address 0
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
         counter_q <= '0;
      end else begin
         state_q   <= state_d;
         counter_q <= counter_d;
      end
   end
   // single write port; old data is seen by same-edge reads on both ports
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end
   // port A registered read, forced to 0 during reset and sweep
   always_ff @(posedge clk) begin
      q_a_q <= (rst || clearing) ? '0 : mem[address_a];
   end
   assign q_a  = q_a_q;
   assign busy = clearing;
   generate
      if (ENABLE_PORT_B != 0) begin : g_port_b
         logic [DATA_WIDTH-1:0] q_b_q;
         // port B registered read, forced to 0 during reset and sweep
         always_ff @(posedge clk) begin
            q_b_q <= (rst || clearing) ? '0 : mem[address_b];
         end
         assign q_b = q_b_q;
      end else begin : g_no_port_b
         assign q_b = '0;
      end
   endgenerate
endmodule

// File: tb/tb_data_memory_ram.sv
// tb_data_memory_ram: directed self-checking bench for data_memory_ram
module tb_data_memory_ram;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [9:0]  address_a = '0, address_b = '0;
   logic [31:0] data_a = '0;
   logic        wren_a = 1'b0;
   logic [31:0] q_a, q_b;
   logic        busy;
   int          passes = 0, total = 0, n;

   data_memory_ram dut (
      .clk(clk), .rst(rst), .address_a(address_a), .data_a(data_a), .wren_a(wren_a),
      .q_a(q_a), .address_b(address_b), .q_b(q_b), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) passes++;
      else $error("FAIL %s: observed %h expected %h", tag, got, exp);
   endtask

   task automatic wr(input logic [9:0] a, input logic [31:0] d);
      @(negedge clk);
      address_a = a; data_a = d; wren_a = 1'b1;
      @(posedge clk);
      @(negedge clk);
      wren_a = 1'b0;
   endtask

   task automatic rd(input string tag, input logic [9:0] a, input logic [9:0] b,
                     input logic [31:0] ea, input logic [31:0] eb);
      @(negedge clk);
      address_a = a; address_b = b; wren_a = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk({tag, "_a"}, q_a, ea);
      chk({tag, "_b"}, q_b, eb);
   endtask

   task automatic count_busy(input string tag, input int release_wren_at);
      n = 0;
      while (busy === 1'b1 && n < 2000) begin
         @(posedge clk);
         #1;
         n++;
         if (n == release_wren_at) wren_a = 1'b0;
      end
      chk(tag, n, 1024);
   endtask

   initial begin
      // reset then sweep
      @(negedge clk); rst = 1'b1;
      @(posedge clk); @(posedge clk);
      @(negedge clk);
      chk("rst_q_a", q_a, 0);
      chk("rst_q_b", q_b, 0);
      chk("rst_busy", {31'd0, busy}, 1);
      rst = 1'b0;
      count_busy("sweep_len", -1);
      chk("busy_low", {31'd0, busy}, 0);
      rd("clr0", 10'd0, 10'd511, 0, 0);
      rd("clr1", 10'd511, 10'd1023, 0, 0);
      rd("clr2", 10'd1023, 10'd0, 0, 0);
      // write/read
      wr(10'd5, 32'hDEADBEEF);
      rd("wr5", 10'd5, 10'd5, 32'hDEADBEEF, 32'hDEADBEEF);
      // read-during-write returns old data
      wr(10'd7, 32'h11);
      @(negedge clk);
      address_a = 10'd7; data_a = 32'h22; wren_a = 1'b1;
      @(posedge clk);
      @(negedge clk);
      wren_a = 1'b0;
      chk("rdw_old", q_a, 32'h11);
      @(posedge clk);
      @(negedge clk);
      chk("rdw_new", q_a, 32'h22);
      // port B collision returns old data, port A unaffected
      @(negedge clk);
      address_a = 10'd1000; data_a = 32'h1234; wren_a = 1'b1; address_b = 10'd1000;
      @(posedge clk);
      @(negedge clk);
      chk("colb_old", q_b, 0);
      wren_a = 1'b0; address_a = 10'd3;
      @(posedge clk);
      @(negedge clk);
      chk("colb_new", q_b, 32'h1234);
      chk("cola_3", q_a, 0);
      // boundary addresses
      wr(10'd0, 32'hA0A00000);
      wr(10'd1023, 32'h5B5B03FF);
      rd("bnd0", 10'd0, 10'd1023, 32'hA0A00000, 32'h5B5B03FF);
      rd("bnd1", 10'd1023, 10'd0, 32'h5B5B03FF, 32'hA0A00000);
      // reset mid-sweep, writes ignored during sweep
      @(negedge clk);
      rst = 1'b1; address_a = 10'd1023; address_b = 10'd1023;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 1; i <= 300; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (i == 3) begin
            chk("swp_q_a", q_a, 0);
            chk("swp_q_b", q_b, 0);
            chk("swp_busy", {31'd0, busy}, 1);
         end
         if (i == 50) begin
            address_a = 10'd10; data_a = 32'hFFFFFFFF; wren_a = 1'b1;
         end
      end
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("mid_busy", {31'd0, busy}, 1);
      rst = 1'b0;
      count_busy("resweep_len", 500);
      rd("discard10", 10'd10, 10'd1023, 0, 0);
      rd("recl1000", 10'd5, 10'd1000, 0, 0);
      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end
endmodule
